// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word memory between an instruction-side line refill
// port (critical-word-first wrapping burst of BURST_LEN beats) and a data-side
// single-word read/write port.
//
// Handshake: a requester raises *_req and holds it (and its address/data) until
// it sees *_done. Each cycle with *_ack=1 carries one beat; the read data is the
// combinational memory data for that beat. After a done pulse the arbiter
// spends one RELEASE cycle with the memory bus idle. The requester can drop its
// request during that cycle without being granted again.
//
// Optional feature: define MEM_ARBITER_RR_EN to settle simultaneous requests
// round-robin. In that mode the first tie after reset goes to D. Without the
// macro, D always wins a tie.
module mem_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic        mem_re,
  output logic        mem_hsel,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IBURST  = 2'd1,
    DACCESS = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int            CW         = 5;
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BURST_LEN - 1);
  // Byte-address bits that select a word inside the line.
  localparam logic [31:0]   LINE_MASK  = 32'((BURST_LEN - 1) << 2);

  state_t        state;
  logic [CW-1:0] beat;
  logic          grant_d;
  logic          grant_i;

`ifdef MEM_ARBITER_RR_EN
  logic last_d;   // 1 when D was the most recent grantee
`endif

  // Address of beat k: the word offset wraps inside the aligned line, and the
  // bits above the line are never touched by the increment.
  function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                            input logic [CW-1:0] k);
    logic [31:0] word;
    logic [31:0] sum;
    word = base & 32'hFFFF_FFFC;
    sum  = word + (32'(k) << 2);
    return (word & ~LINE_MASK) | (sum & LINE_MASK);
  endfunction

  // Arbitration between simultaneous requests sampled in IDLE.
  always_comb begin
`ifdef MEM_ARBITER_RR_EN
    grant_d = d_req && (!i_req || !last_d);
`else
    grant_d = d_req;
`endif
    grant_i = i_req && !grant_d;
  end

  // Main FSM. All outputs are registered, except the read-data paths below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat     <= '0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      i_ack    <= 1'b0;
      i_done   <= 1'b0;
      d_ack    <= 1'b0;
      d_done   <= 1'b0;
      mem_a    <= '0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      mem_hsel <= 1'b0;
      mem_wd   <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_d   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= DACCESS;
            owner    <= 1'b1;
            busy     <= 1'b1;
            d_ack    <= 1'b1;
            d_done   <= 1'b1;
            mem_a    <= d_addr & 32'hFFFF_FFFC;
            mem_we   <= d_we;
            mem_re   <= ~d_we;
            mem_hsel <= 1'b1;
            mem_wd   <= d_wdata;
`ifdef MEM_ARBITER_RR_EN
            last_d   <= 1'b1;
`endif
          end else if (grant_i) begin
            state    <= IBURST;
            owner    <= 1'b0;
            busy     <= 1'b1;
            beat     <= '0;
            i_ack    <= 1'b1;
            i_done   <= (LAST_BEAT == '0);
            mem_a    <= beat_addr(i_addr, '0);
            mem_we   <= 1'b0;
            mem_re   <= 1'b1;
            mem_hsel <= 1'b1;
            mem_wd   <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_d   <= 1'b0;
`endif
          end
        end
        IBURST: begin
          if (beat == LAST_BEAT) begin
            state    <= RELEASE;
            beat     <= '0;
            i_ack    <= 1'b0;
            i_done   <= 1'b0;
            mem_a    <= '0;
            mem_re   <= 1'b0;
            mem_hsel <= 1'b0;
          end else begin
            beat   <= beat + CW'(1);
            mem_a  <= beat_addr(i_addr, beat + CW'(1));
            i_done <= ((beat + CW'(1)) == LAST_BEAT);
          end
        end
        DACCESS: begin
          state    <= RELEASE;
          d_ack    <= 1'b0;
          d_done   <= 1'b0;
          mem_a    <= '0;
          mem_we   <= 1'b0;
          mem_re   <= 1'b0;
          mem_hsel <= 1'b0;
          mem_wd   <= '0;
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data passes straight from memory during a read beat, and is zero otherwise.
  always_comb begin
    i_rdata = i_ack ? mem_rd : '0;
    d_rdata = (d_ack && !mem_we) ? mem_rd : '0;
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (BURST_LEN = 4) with a behavioural word
// memory. Driver tasks queue the hand-computed beats they expect. A monitor on
// the falling clock edge pops one entry for every acknowledged beat. It also
// checks that the memory bus is idle in RELEASE.
module tb_mem_arbiter;

  localparam int BL = 4;
  localparam int W  = 70;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] mem_a;
  logic        mem_we;
  logic        mem_re;
  logic        mem_hsel;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;
  logic        owner;
  logic [1:0]  fsm_state;

  logic [31:0] mem [0:1023];
  logic [W-1:0] exp_q[$];
  int compared = 0;
  int failed   = 0;

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;
  localparam logic [31:0] WD = 32'hDDDD_0004;

  mem_arbiter #(.BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_done(d_done),
    .mem_a(mem_a), .mem_we(mem_we), .mem_re(mem_re), .mem_hsel(mem_hsel),
    .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .owner(owner), .fsm_state(fsm_state)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge.
  assign mem_rd = mem[mem_a[11:2]];
  always @(posedge clk) begin
    if (mem_hsel && mem_we) mem[mem_a[11:2]] <= mem_wd;
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beat records: {src, owner, done, we, re, hsel, addr, data}.
  function automatic logic [W-1:0] exp_i(input logic [31:0] a, input logic [31:0] d,
                                         input logic done);
    return {1'b0, 1'b0, done, 1'b0, 1'b1, 1'b1, a, d};
  endfunction

  function automatic logic [W-1:0] exp_d(input logic we, input logic [31:0] a,
                                         input logic [31:0] d);
    return {1'b1, 1'b1, 1'b1, we, ~we, 1'b1, a, d};
  endfunction

  // Monitor: compares every presented beat against the queue.
  always @(negedge clk) begin
    logic [W-1:0] act;
    if (reset) begin
      if (i_ack || d_ack) begin
        act = {d_ack, owner, (d_ack ? d_done : i_done), mem_we, mem_re, mem_hsel,
               mem_a, (d_ack ? d_rdata : i_rdata)};
        if (exp_q.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected_beat: got %0h expected none", act);
        end else begin
          check("beat", 160'(act), 160'(exp_q.pop_front()));
        end
      end else if (fsm_state == 2'd3) begin
        check("release_bus_idle", 160'({busy, mem_a, mem_we, mem_re, mem_hsel, mem_wd}),
              160'({1'b1, 67'b0}));
      end
    end
  end

  // Waits for i_done (want_d=0) or d_done (want_d=1), sampling 1 time unit after each rising edge.
  task automatic wait_done(input bit want_d, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (want_d ? d_done : i_done) seen = 1'b1;
    end
    if (!seen) begin
      compared++;
      failed++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cycles);
    end
  endtask

  task automatic i_refill(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
    int c;
    exp_q.push_back(exp_i(a0, d0, 1'b0));
    exp_q.push_back(exp_i(a1, d1, 1'b0));
    exp_q.push_back(exp_i(a2, d2, 1'b0));
    exp_q.push_back(exp_i(a3, d3, 1'b1));
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = addr;
    wait_done(1'b0, c);
    check("refill_latency", 160'(c), 160'(BL));
    i_req = 1'b0;
    @(posedge clk); #1;
    check("release_state", 160'({busy, fsm_state}), 160'({1'b1, 2'd3}));
    @(posedge clk); #1;
    check("back_to_idle", 160'({busy, fsm_state, owner}), 160'({1'b0, 2'd0, 1'b0}));
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_a, input logic [31:0] exp_rd);
    int c;
    exp_q.push_back(exp_d(we, exp_a, exp_rd));
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    wait_done(1'b1, c);
    check("daccess_latency", 160'(c), 160'(1));
    if (we) check("write_data", 160'(mem_wd), 160'(wdata));
    d_req = 1'b0;
    @(posedge clk); #1;
    check("d_release_state", 160'({busy, owner, fsm_state}), 160'({1'b1, 1'b1, 2'd3}));
    @(posedge clk);
  endtask

  // Directed sequence.
  initial begin
    int c;
    int n;
    logic [3:0] order;
    logic [3:0] exp_order;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i * 4);
    mem[32'h100 >> 2] = WA;
    mem[32'h104 >> 2] = WB;
    mem[32'h108 >> 2] = WC;
    mem[32'h10C >> 2] = WD;
    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1;
    check("reset_outputs",
          160'({i_ack, i_rdata, i_done, d_ack, d_rdata, d_done, mem_a, mem_we, mem_re}),
          160'(0));
    check("reset_outputs2", 160'({mem_hsel, mem_wd, busy, owner, fsm_state}), 160'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Critical-word-first refill: C, D, A, B.
    i_refill(32'h108, WC, WD, WA, WB, 32'h108, 32'h10C, 32'h100, 32'h104);
    // Unaligned write, then read it back.
    d_access(1'b1, 32'h203, 32'hDEAD_BEEF, 32'h200, 32'h0);
    d_access(1'b0, 32'h200, 32'h0, 32'h200, 32'hDEAD_BEEF);
    d_access(1'b0, 32'h10E, 32'h0, 32'h10C, WD);
    // Other start offset, and a wrap at the top of a line with high address bits.
    i_refill(32'h104, WB, WC, WD, WA, 32'h104, 32'h108, 32'h10C, 32'h100);
    i_refill(32'h3FC, 32'h5A0003FC, 32'h5A0003F0, 32'h5A0003F4, 32'h5A0003F8,
             32'h3FC, 32'h3F0, 32'h3F4, 32'h3F8);

    // Simultaneous requests, both held: three contested grants, then D drops.
`ifdef MEM_ARBITER_RR_EN
    exp_order = 4'b1010;
    exp_q.push_back(exp_d(1'b0, 32'h300, 32'h5A000300));
    exp_q.push_back(exp_i(32'h180, 32'h5A000180, 1'b0));
    exp_q.push_back(exp_i(32'h184, 32'h5A000184, 1'b0));
    exp_q.push_back(exp_i(32'h188, 32'h5A000188, 1'b0));
    exp_q.push_back(exp_i(32'h18C, 32'h5A00018C, 1'b1));
    exp_q.push_back(exp_d(1'b0, 32'h300, 32'h5A000300));
`else
    exp_order = 4'b1110;
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_d(1'b0, 32'h300, 32'h5A000300));
`endif
    exp_q.push_back(exp_i(32'h180, 32'h5A000180, 1'b0));
    exp_q.push_back(exp_i(32'h184, 32'h5A000184, 1'b0));
    exp_q.push_back(exp_i(32'h188, 32'h5A000188, 1'b0));
    exp_q.push_back(exp_i(32'h18C, 32'h5A00018C, 1'b1));
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h180;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    n = 0;
    order = '0;
    for (int cyc = 0; cyc < 100 && n < 4; cyc++) begin
      @(posedge clk); #1;
      if (d_done || i_done) begin
        order = {order[2:0], d_done};
        n++;
        if (n == 3) d_req = 1'b0;
        if (n == 4) i_req = 1'b0;
      end
    end
    check("tie_grant_order", 160'(order), 160'(exp_order));
    check("tie_completions", 160'(n), 160'(4));
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);

    // D request arriving during burst beat 1 waits for the burst and RELEASE.
    exp_q.push_back(exp_i(32'h100, WA, 1'b0));
    exp_q.push_back(exp_i(32'h104, WB, 1'b0));
    exp_q.push_back(exp_i(32'h108, WC, 1'b0));
    exp_q.push_back(exp_i(32'h10C, WD, 1'b1));
    exp_q.push_back(exp_d(1'b0, 32'h204, 32'h5A000204));
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
    wait_done(1'b0, c);
    check("burst_undisturbed_len", 160'(c), 160'(BL - 2));
    i_req = 1'b0;
    wait_done(1'b1, c);
    check("d_after_release_gap", 160'(c), 160'(3));
    d_req = 1'b0;
    repeat (3) @(posedge clk);

    // Reset at burst beat 2 aborts without done; the held request then restarts from beat 0.
    exp_q.push_back(exp_i(32'h100, WA, 1'b0));
    exp_q.push_back(exp_i(32'h104, WB, 1'b0));
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("abort_outputs",
          160'({i_ack, i_rdata, i_done, busy, owner, fsm_state, mem_a, mem_re, mem_hsel}),
          160'(0));
    check("abort_queue_drained", 160'(exp_q.size()), 160'(0));
    exp_q.push_back(exp_i(32'h100, WA, 1'b0));
    exp_q.push_back(exp_i(32'h104, WB, 1'b0));
    exp_q.push_back(exp_i(32'h108, WC, 1'b0));
    exp_q.push_back(exp_i(32'h10C, WD, 1'b1));
    @(negedge clk);
    reset = 1'b1;
    wait_done(1'b0, c);
    check("restart_latency", 160'(c), 160'(BL));
    i_req = 1'b0;
    repeat (3) @(posedge clk);

    check("queue_empty_at_end", 160'(exp_q.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
